// File: rtl/fd_skid_pipe_reg.sv
// Fetch/decode pipeline register with a two-entry skid buffer and valid/ready on both sides.
// in_ready and every output come straight from flops, so decode backpressure never reaches fetch combinationally.
module fd_skid_pipe_reg #(
    parameter int                 INST_W      = 32,
    parameter int                 PC_IN_W     = 16,
    parameter int                 PC_OUT_W    = 32,
    parameter logic [INST_W-1:0]  BUBBLE_INST = 32'hffffffff,
    parameter int                 CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INST_W-1:0]   in_inst,
    input  logic [PC_IN_W-1:0]  in_pc,
    input  logic                in_guess,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INST_W-1:0]   out_inst,
    output logic [PC_OUT_W-1:0] out_pc,
    output logic                out_guess,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [INST_W-1:0]     out_inst_q, out_inst_d;
    logic [PC_OUT_W-1:0]   out_pc_q, out_pc_d;
    logic                  out_guess_q, out_guess_d;
    logic [INST_W-1:0]     skid_inst_q, skid_inst_d;
    logic [PC_IN_W-1:0]    skid_pc_q, skid_pc_d;
    logic                  skid_guess_q, skid_guess_d;
    logic                  in_ready_q, in_ready_d;
    logic [1:0]            occ_q, occ_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic accept, drain;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid must not depend on ready, and in_ready is a pure flop output.
    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            out_inst_q   <= BUBBLE_INST;
            out_pc_q     <= '0;
            out_guess_q  <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
            skid_guess_q <= 1'b0;
            in_ready_q   <= 1'b1;
            occ_q        <= 2'd0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            out_guess_q  <= out_guess_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            skid_guess_q <= skid_guess_d;
            in_ready_q   <= in_ready_d;
            occ_q        <= occ_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !drain)      state_d = ST_FULL;
                else if (!accept && drain) state_d = ST_EMPTY;
            end
            ST_FULL:  if (drain) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    // Datapath and registered outputs; the main entry is stored already bubble-encoded
    always_comb begin
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        out_guess_d  = out_guess_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        skid_guess_d = skid_guess_q;
        if (state_d == ST_EMPTY) begin
            out_inst_d  = BUBBLE_INST;
            out_pc_d    = '0;
            out_guess_d = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY, ST_ONE: begin
                    if (accept && (drain || state_q == ST_EMPTY)) begin
                        out_inst_d  = in_inst;
                        out_pc_d    = PC_OUT_W'(in_pc);
                        out_guess_d = in_guess;
                    end else if (accept) begin
                        skid_inst_d  = in_inst;
                        skid_pc_d    = in_pc;
                        skid_guess_d = in_guess;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        out_inst_d  = skid_inst_q;
                        out_pc_d    = PC_OUT_W'(skid_pc_q);
                        out_guess_d = skid_guess_q;
                    end
                end
                default: ;
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        occ_d       = (state_d == ST_FULL) ? 2'd2 : (state_d == ST_ONE) ? 2'd1 : 2'd0;
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;
    assign out_guess = out_guess_q;
    assign occupancy = occ_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fd_skid_pipe_reg.sv
// Bench for fd_skid_pipe_reg: directed scenarios plus a randomized run against a queue-based model.
// A second instance with a 3-bit stall counter covers saturation.
module tb_fd_skid_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_guess, out_ready;
  logic [31:0] in_inst;
  logic [15:0] in_pc;
  logic        in_ready, out_valid, out_guess;
  logic [31:0] out_inst, out_pc;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic        s_in_ready, s_out_valid, s_out_guess;
  logic [31:0] s_out_inst, s_out_pc;
  logic [1:0]  s_occupancy;
  logic [2:0]  s_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [15:0] pc;
    logic        guess;
  } entry_t;

  entry_t      m_q[$];
  logic [15:0] m_cnt  = '0;
  logic [2:0]  m_cnt3 = '0;

  always #5 clk = ~clk;

  fd_skid_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_guess(in_guess), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_guess(out_guess),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  fd_skid_pipe_reg #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_guess(in_guess), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_inst(s_out_inst), .out_pc(s_out_pc), .out_guess(s_out_guess),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  // Advance one clock; the model applies the same edge using the pre-edge inputs.
  task automatic step();
    bit has_room, drain, acc;
    has_room = (m_q.size() < 2);
    drain    = (m_q.size() != 0) && out_ready;
    acc      = in_valid && has_room;
    if (rst) begin
      m_q.delete();
      m_cnt  = '0;
      m_cnt3 = '0;
    end else begin
      if (m_q.size() != 0 && !out_ready) begin
        if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
        if (m_cnt3 != 3'd7) m_cnt3 = m_cnt3 + 3'd1;
      end
      if (flush) m_q.delete();
      else begin
        if (drain) void'(m_q.pop_front());
        if (acc) m_q.push_back(entry_t'{in_inst, in_pc, in_guess});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [15:0] pc, input logic g);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
    in_guess = g;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h12345678, 16'h1234, 1'b1);
    step();
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_inst !== 32'hffffffff) begin n_fail++; $display("FAIL reset_out_inst: got %h expected ffffffff", out_inst); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    n_checks++; if (out_guess !== 1'b0) begin n_fail++; $display("FAIL reset_out_guess: got %b expected 0", out_guess); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    rst = 1'b0;
    drive(1'b0, 32'h0, 16'h0, 1'b0);
  endtask

  task automatic test_streaming();
    logic [31:0] insts[3];
    logic [15:0] pcs[3];
    insts = '{32'h00000013, 32'h00a00093, 32'h00b00113};
    pcs   = '{16'h0000, 16'h0004, 16'h0008};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, insts[i], pcs[i], 1'b0);
      step();
      n_checks++; if (out_valid !== 1'b1 || out_inst !== insts[i]) begin n_fail++; $display("FAIL stream_inst%0d: got %b/%h expected 1/%h", i, out_valid, out_inst, insts[i]); end
      n_checks++; if (out_pc !== {16'h0, pcs[i]}) begin n_fail++; $display("FAIL stream_pc%0d: got %h expected %h", i, out_pc, {16'h0, pcs[i]}); end
      n_checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_occ%0d: got occ %0d rdy %b expected occ 1 rdy 1", i, occupancy, in_ready); end
    end
    drive(1'b0, 32'h0, 16'h0, 1'b0);
    step();
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_empty: got valid %b occ %0d expected 0 0", out_valid, occupancy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'haaaa0001, 16'h0010, 1'b0);
    step();
    drive(1'b1, 32'hbbbb0002, 16'h0014, 1'b1);
    step();
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full: got %0d expected 2", occupancy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_inst !== 32'haaaa0001 || out_pc !== 32'h10) begin n_fail++; $display("FAIL bp_out_a: got %h/%h expected aaaa0001/00000010", out_inst, out_pc); end
    drive(1'b1, 32'hcccc0003, 16'h0018, 1'b0);
    step();
    step();
    n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d expected 3", stall_cnt); end
    n_checks++; if (occupancy !== 2'd2 || out_inst !== 32'haaaa0001) begin n_fail++; $display("FAIL bp_hold: got occ %0d inst %h expected 2 aaaa0001", occupancy, out_inst); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_inst !== 32'hbbbb0002 || out_guess !== 1'b1 || out_pc !== 32'h14) begin n_fail++; $display("FAIL bp_drain_b: got %h/%h/%b expected bbbb0002/00000014/1", out_inst, out_pc, out_guess); end
    n_checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_ready_back: got rdy %b occ %0d expected 1 1", in_ready, occupancy); end
    step();
    n_checks++; if (out_inst !== 32'hcccc0003 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_c: got %h valid %b expected cccc0003 1", out_inst, out_valid); end
    drive(1'b0, 32'h0, 16'h0, 1'b0);
    step();
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL bp_empty: got valid %b occ %0d expected 0 0", out_valid, occupancy); end
    n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_stall_hold: got %0d expected 3", stall_cnt); end
  endtask

  task automatic test_flush();
    logic [15:0] cnt_before;
    out_ready = 1'b0;
    drive(1'b1, 32'h11110001, 16'h0020, 1'b1);
    step();
    drive(1'b1, 32'h22220002, 16'h0024, 1'b0);
    step();
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre_full: got %0d expected 2", occupancy); end
    cnt_before = stall_cnt;
    flush = 1'b1;
    drive(1'b1, 32'h33330003, 16'h0028, 1'b1);
    step();
    flush = 1'b0;
    n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_empty: got occ %0d valid %b expected 0 0", occupancy, out_valid); end
    n_checks++; if (out_inst !== 32'hffffffff || out_pc !== 32'h0 || out_guess !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: got %h/%h/%b expected ffffffff/00000000/0", out_inst, out_pc, out_guess); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (stall_cnt !== cnt_before + 16'd1) begin n_fail++; $display("FAIL flush_stall_cnt: got %0d expected %0d", stall_cnt, cnt_before + 16'd1); end
    drive(1'b0, 32'h0, 16'h0, 1'b0);
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost: got %b expected 0", out_valid); end
    // flush in ONE while fetch is accepted: the incoming entry must vanish
    drive(1'b1, 32'h44440004, 16'h002c, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h55550005, 16'h0030, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 16'h0, 1'b0);
    step();
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_one_accept: got valid %b occ %0d expected 0 0", out_valid, occupancy); end
  endtask

  task automatic test_zext_guess();
    out_ready = 1'b1;
    drive(1'b1, 32'hdeadbeef, 16'hfffc, 1'b1);
    step();
    n_checks++; if (out_pc !== 32'h0000fffc || out_guess !== 1'b1) begin n_fail++; $display("FAIL zext_pc_guess: got %h/%b expected 0000fffc/1", out_pc, out_guess); end
    drive(1'b0, 32'h0, 16'h0, 1'b0);
    step();
    n_checks++; if (out_pc !== 32'h0 || out_guess !== 1'b0 || out_inst !== 32'hffffffff) begin n_fail++; $display("FAIL zext_after_drain: got %h/%b/%h expected 00000000/0/ffffffff", out_pc, out_guess, out_inst); end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h77770007, 16'h0040, 1'b0);
    step();
    drive(1'b0, 32'h0, 16'h0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 7) begin
        n_checks++; if (s_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_reach7: got %0d expected 7", s_stall_cnt); end
      end
    end
    n_checks++; if (s_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_hold7: got %0d expected 7", s_stall_cnt); end
    n_checks++; if (stall_cnt !== 16'd10) begin n_fail++; $display("FAIL sat_wide10: got %0d expected 10", stall_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (s_stall_cnt !== 3'd0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL sat_rst_clear: got %0d/%0d expected 0/0", s_stall_cnt, stall_cnt); end
  endtask

  task automatic test_random();
    logic        e_valid, e_guess;
    logic [31:0] e_inst, e_pc;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive(($urandom_range(0, 3) != 0), $urandom(), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      step();
      e_valid = (m_q.size() != 0);
      e_inst  = e_valid ? m_q[0].inst : 32'hffffffff;
      e_pc    = e_valid ? {16'h0, m_q[0].pc} : 32'h0;
      e_guess = e_valid ? m_q[0].guess : 1'b0;
      n_checks++; if (out_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, out_valid, e_valid); end
      n_checks++; if (out_inst !== e_inst || out_pc !== e_pc || out_guess !== e_guess) begin n_fail++; $display("FAIL rnd_data c%0d: got %h/%h/%b expected %h/%h/%b", c, out_inst, out_pc, out_guess, e_inst, e_pc, e_guess); end
      n_checks++; if (occupancy !== 2'(m_q.size()) || in_ready !== (m_q.size() < 2)) begin n_fail++; $display("FAIL rnd_occ c%0d: got occ %0d rdy %b expected occ %0d", c, occupancy, in_ready, m_q.size()); end
      n_checks++; if (stall_cnt !== m_cnt || s_stall_cnt !== m_cnt3) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0d/%0d expected %0d/%0d", c, stall_cnt, s_stall_cnt, m_cnt, m_cnt3); end
    end
    rst = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 16'h0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_zext_guess();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
